// File: rtl/observer_pkg.sv
// Shared definitions for observer and its readout sequencer:
// mode encoding, bus widths, frame header and item mapping.
package observer_pkg;

  localparam int REG_BUS_W  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_FIXED  = 5;
  localparam int NUM_ITEMS  = 21;
  localparam int ITEM_W     = 5;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    MODE_PC    = 3'd0,
    MODE_IR    = 3'd1,
    MODE_ALU_A = 3'd2,
    MODE_ALU_B = 3'd3,
    MODE_ALU_O = 3'd4,
    MODE_REG   = 3'd5
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEL,
    S_HI,
    S_LO,
    S_CSUM
  } dump_state_e;

  function automatic mode_e item_mode(
    input logic [ITEM_W-1:0] item
  );
    if (item < ITEM_W'(NUM_FIXED))
      return mode_e'(item[2:0]);
    return MODE_REG;
  endfunction

  function automatic logic [REG_ADDR_W-1:0] item_sel(
    input logic [ITEM_W-1:0] item
  );
    if (item < ITEM_W'(NUM_FIXED))
      return '0;
    return REG_ADDR_W'(item - ITEM_W'(NUM_FIXED));
  endfunction

endpackage

// File: rtl/observer_dumper.sv
// Steps observer through every observable value and streams the
// snapshot as HEADER, 21 big-endian words and an XOR checksum.
module observer_dumper
  import observer_pkg::*;
#(
  parameter logic [7:0] HEADER   = HEADER_DEF,
  parameter int         NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic [2:0]            mode_o,
  output logic [REG_ADDR_W-1:0] reg_sel_o,
  input  logic [REG_BUS_W-1:0]  data_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ITEM_W-1:0] LAST_ITEM =
    ITEM_W'(NUM_FIXED + NUM_REGS - 1);

  dump_state_e            state_q;
  logic [ITEM_W-1:0]      item_q;
  logic [ITEM_W-1:0]      next_item;
  logic [REG_BUS_W-1:0]   word_q;
  logic [7:0]             acc_q;
  logic                   xfer;

  assign next_item = item_q + ITEM_W'(1);
  assign xfer      = byte_valid_o && byte_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      item_q       <= '0;
      word_q       <= '0;
      acc_q        <= '0;
      mode_o       <= '0;
      reg_sel_o    <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_HDR;
            item_q       <= '0;
            acc_q        <= '0;
            byte_o       <= HEADER;
            byte_valid_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        S_HDR: begin
          if (xfer) begin
            state_q      <= S_SEL;
            byte_valid_o <= 1'b0;
            mode_o       <= item_mode(item_q);
            reg_sel_o    <= item_sel(item_q);
          end
        end
        S_SEL: begin
          // observer output has settled for a full cycle here
          state_q      <= S_HI;
          word_q       <= data_i;
          byte_o       <= data_i[15:8];
          byte_valid_o <= 1'b1;
        end
        S_HI: begin
          if (xfer) begin
            state_q <= S_LO;
            acc_q   <= acc_q ^ byte_o;
            byte_o  <= word_q[7:0];
          end
        end
        S_LO: begin
          if (xfer) begin
            acc_q <= acc_q ^ byte_o;
            if (item_q == LAST_ITEM) begin
              state_q <= S_CSUM;
              byte_o  <= acc_q ^ byte_o;
            end else begin
              state_q      <= S_SEL;
              item_q       <= next_item;
              byte_valid_o <= 1'b0;
              mode_o       <= item_mode(next_item);
              reg_sel_o    <= item_sel(next_item);
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_q      <= S_IDLE;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          byte_valid_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
